// File: rtl/pkg_hazard_unit.sv
// Shared types for the pipeline hazard controller: forwarding select codes,
// the per-stage shadow slot and the slot match helper.
package pkg_hazard_unit;

  localparam int unsigned HZ_REG_W  = 5;
  localparam int unsigned FWD_SEL_W = 2;

  localparam logic [HZ_REG_W-1:0] REG_ZERO = '0;

  localparam logic [FWD_SEL_W-1:0] FWD_SEL_EX  = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_WB  = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_SEL_MEM = 2'b10;

  typedef enum logic [FWD_SEL_W-1:0] {
    FORWARD_A__EXECUTE_RD1       = 2'b00,
    FORWARD_A__WRITE_BACK_RESULT = 2'b01,
    FORWARD_A__MEMORY_ALU_RESULT = 2'b10
  } forward_a_t;

  typedef enum logic [FWD_SEL_W-1:0] {
    FORWARD_B__EXECUTE_RD2       = 2'b00,
    FORWARD_B__WRITE_BACK_RESULT = 2'b01,
    FORWARD_B__MEMORY_ALU_RESULT = 2'b10
  } forward_b_t;

  typedef struct packed {
    logic [HZ_REG_W-1:0] rd;
    logic [HZ_REG_W-1:0] rs1;
    logic [HZ_REG_W-1:0] rs2;
    logic                we;
    logic                load;
  } hazard_slot_t;

  // A slot supplies a value for idx only if it writes a non-x0 register equal to idx.
  function automatic logic slot_hit(input hazard_slot_t s, input logic [HZ_REG_W-1:0] idx);
    return s.we & (s.rd != REG_ZERO) & (s.rd == idx);
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Per-operand forwarding select: the M slot wins over the W slot, x0 never forwards.
module hazard_fwd_match
  import pkg_hazard_unit::*;
(
  input  logic [HZ_REG_W-1:0]  src_idx,
  input  hazard_slot_t         m_slot,
  input  hazard_slot_t         w_slot,
  output logic [FWD_SEL_W-1:0] sel_c
);

  logic unused_slot_bits;
  assign unused_slot_bits = ^{m_slot.rs1, m_slot.rs2, m_slot.load,
                              w_slot.rs1, w_slot.rs2, w_slot.load};

  always_comb begin
    sel_c = FWD_SEL_EX;
    if (slot_hit(m_slot, src_idx)) begin
      sel_c = FWD_SEL_MEM;
    end else if (slot_hit(w_slot, src_idx)) begin
      sel_c = FWD_SEL_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows E/M/W destination state and drives
// forwarding selects, load-use stall, branch flush, dmem-wait freeze and a stall counter.
module hazard_ctrl
  import pkg_hazard_unit::*;
#(
  parameter int unsigned REG_ADDR_W = HZ_REG_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_pc_src,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output forward_a_t            forward_a,
  output forward_b_t            forward_b,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [CNT_W-1:0]      stall_count
);

  hazard_slot_t e_q, e_d;
  hazard_slot_t m_q, m_d;
  hazard_slot_t w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mwait_c;
  logic lu_c;
  logic hit_rs1_c;
  logic hit_rs2_c;
  logic [FWD_SEL_W-1:0] sel_a_c;
  logic [FWD_SEL_W-1:0] sel_b_c;

  // Hazard condition terms.
  always_comb begin
    mwait_c   = mem_req & ~mem_ready;
    hit_rs1_c = id_use_rs1 & (HZ_REG_W'(id_rs1) == e_q.rd);
    hit_rs2_c = id_use_rs2 & (HZ_REG_W'(id_rs2) == e_q.rd);
    lu_c      = e_q.load & e_q.we & (e_q.rd != REG_ZERO) & (hit_rs1_c | hit_rs2_c);
  end

  // Stall/flush priority: dmem wait freezes everything and defers any branch flush.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mwait_c) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (ex_pc_src) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu_c) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Shadow slot advance; a frozen M is not allowed to write back twice.
  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (mwait_c) begin
      w_d = '0;
    end else begin
      w_d = m_q;
      m_d = e_q;
      if (flush_e) begin
        e_d = '0;
      end else begin
        e_d.rd   = HZ_REG_W'(id_rd);
        e_d.rs1  = HZ_REG_W'(id_rs1);
        e_d.rs2  = HZ_REG_W'(id_rs2);
        e_d.we   = id_reg_write;
        e_d.load = id_is_load;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_f && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  hazard_fwd_match u_fwd_a (
    .src_idx (e_q.rs1),
    .m_slot  (m_q),
    .w_slot  (w_q),
    .sel_c   (sel_a_c)
  );

  hazard_fwd_match u_fwd_b (
    .src_idx (e_q.rs2),
    .m_slot  (m_q),
    .w_slot  (w_q),
    .sel_c   (sel_b_c)
  );

  assign forward_a   = forward_a_t'(sel_a_c);
  assign forward_b   = forward_b_t'(sel_b_c);
  assign stall_count = cnt_q;

endmodule
